edge_stream_filter: RTL

Streaming 3x3 neighbourhood filter for the edge-detection pipeline: it replaces whole-image array hand-off with a raster pixel stream and valid/ready handshakes on both sides. Selectable modes: Sobel gradient magnitude, thresholded binary edge map, Gaussian blur, or pass-through. The block sits between the pixel source (camera/memory reader) and downstream stages (non-maximum suppression, hysteresis), one frame per `start`.

---
 rtl/edge_stream_filter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/edge_stream_filter.sv
// Streaming 3x3 neighbourhood filter (Sobel magnitude, binary threshold, Gaussian, pass-through)
// over a raster pixel stream with valid/ready handshakes; valid-only convolution, one frame per start.
module edge_stream_filter #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 512,
    parameter int IMG_H = 512
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [PIX_W-1:0] thresh,
    input  logic [PIX_W-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [PIX_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             frame_done
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H + 1);
    localparam int GW = PIX_W + 3;
    localparam int SW = PIX_W + 4;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    state_t r_state, w_next;

    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic [1:0]       r_mode;
    logic [PIX_W-1:0] r_thresh;

    logic [PIX_W-1:0] r_lb1 [IMG_W];
    logic [PIX_W-1:0] r_lb2 [IMG_W];
    logic [PIX_W-1:0] r_win [3][2];
    logic [PIX_W-1:0] w_win [3][3];

    logic [PIX_W-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_out_last;
    logic             r_frame_done;

    logic w_accept, w_last_pix, w_emit, w_in_ready, w_busy;

    logic signed [GW-1:0] w_e [3][3];
    logic signed [GW-1:0] w_gx, w_gy;
    logic [GW-1:0]        w_ax, w_ay, w_mag;
    logic [SW-1:0]        w_gsum;
    logic [PIX_W-1:0]     w_sat, w_gauss, w_result;

    assign w_accept   = in_valid && w_in_ready;
    assign w_last_pix = (r_row == ROW_LAST) && (r_col == COL_LAST);
    assign w_emit     = w_accept && (r_row >= RW'(2)) && (r_col >= CW'(2));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_RUN;
            ST_RUN:   if (w_accept && w_last_pix) w_next = ST_DRAIN;
            ST_DRAIN: if (r_out_valid && out_ready && r_out_last) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy     = 1'b0;
        w_in_ready = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_busy     = 1'b1;
                w_in_ready = !r_out_valid || out_ready;
            end
            ST_DRAIN: w_busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_col    <= '0;
            r_row    <= '0;
            r_mode   <= '0;
            r_thresh <= '0;
        end else if (r_state == ST_IDLE) begin
            r_col <= '0;
            r_row <= '0;
            if (start) begin
                r_mode   <= mode;
                r_thresh <= thresh;
            end
        end else if (w_accept) begin
            if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Newest window column: row r-2 and r-1 from the line buffers, row r from the input.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_win[i][0] = r_win[i][0];
            w_win[i][1] = r_win[i][1];
        end
        w_win[0][2] = r_lb2[r_col];
        w_win[1][2] = r_lb1[r_col];
        w_win[2][2] = in_data;
    end

    // NOTE: line buffers and window are storage only; they are rewritten before any output reads them, so no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb2[r_col] <= r_lb1[r_col];
            r_lb1[r_col] <= in_data;
            for (int i = 0; i < 3; i++) begin
                r_win[i][0] <= w_win[i][1];
                r_win[i][1] <= w_win[i][2];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w_e[i][j] = GW'(w_win[i][j]);
            end
        end
        w_gx = (w_e[0][2] + (w_e[1][2] <<< 1) + w_e[2][2])
             - (w_e[0][0] + (w_e[1][0] <<< 1) + w_e[2][0]);
        w_gy = (w_e[2][0] + (w_e[2][1] <<< 1) + w_e[2][2])
             - (w_e[0][0] + (w_e[0][1] <<< 1) + w_e[0][2]);
        w_ax  = w_gx[GW-1] ? -w_gx : w_gx;
        w_ay  = w_gy[GW-1] ? -w_gy : w_gy;
        w_mag = w_ax + w_ay;
        w_sat = (|w_mag[GW-1:PIX_W]) ? '1 : w_mag[PIX_W-1:0];

        w_gsum = SW'(w_win[0][0]) + (SW'(w_win[0][1]) << 1) + SW'(w_win[0][2])
               + (SW'(w_win[1][0]) << 1) + (SW'(w_win[1][1]) << 2) + (SW'(w_win[1][2]) << 1)
               + SW'(w_win[2][0]) + (SW'(w_win[2][1]) << 1) + SW'(w_win[2][2]);
        w_gauss = w_gsum[SW-1:4];

        case (r_mode)
            2'd0:    w_result = w_sat;
            2'd1:    w_result = (w_sat >= r_thresh) ? '1 : '0;
            2'd2:    w_result = w_gauss;
            default: w_result = w_win[1][1];
        endcase
    end

    // Acceptance only happens with the output slot free, so a new result never overwrites a pending one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_emit) begin
                r_out_data  <= w_result;
                r_out_valid <= 1'b1;
                r_out_last  <= w_last_pix;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
            r_frame_done <= (r_state == ST_DRAIN) && r_out_valid && out_ready && r_out_last;
        end
    end

    assign in_ready   = w_in_ready;
    assign busy       = w_busy;
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
    assign frame_done = r_frame_done;

endmodule
